// File: rtl/ss_idft_pkg.sv
// Shared sizing helpers and types for the single-sample inverse DFT.
package ss_idft_pkg;

   localparam int DW_DEF = 16;
   localparam int N_DEF  = 8;

   function automatic int acc_width(input int dw, input int n);
      return dw + $clog2(n);
   endfunction

   function automatic int rnd_of(input int log2n);
      return 1 << (log2n - 1);
   endfunction

   localparam int LOG2N_DEF = $clog2(N_DEF);
   localparam int AW_DEF    = acc_width(DW_DEF, N_DEF);
   localparam int RND       = 1 << (LOG2N_DEF - 1);

   typedef logic signed [AW_DEF-1:0] acc_t;

endpackage

// File: rtl/ss_idft_round.sv
// Divides the frame sum by N: round half up, then arithmetic shift right by LOG2N.
module ss_idft_round
   import ss_idft_pkg::*;
#(
   parameter int DW    = 16,
   parameter int LOG2N = 3
) (
   input  logic signed [DW+LOG2N-1:0] acc_i,
   output logic signed [DW-1:0]       sample_o
);

   localparam int AW = DW + LOG2N;
   localparam logic signed [AW-1:0] RND_C = AW'(rnd_of(LOG2N));

   logic signed [AW-1:0] biased;
   logic                 unused_frac;

   // The sum of N DW-bit values plus N/2 still fits AW bits, so no guard bit is needed.
   always_comb begin
      biased = acc_i + RND_C;
   end

   assign sample_o    = biased[AW-1:LOG2N];
   assign unused_frac = ^biased[LOG2N-1:0];

endmodule

// File: rtl/ss_idft.sv
// Single-sample inverse DFT: accumulates the real parts of one streamed frame
// and emits their rounded mean as time sample x0, one clock after end of frame.
module ss_idft
   import ss_idft_pkg::*;
#(
   parameter int DW = 16,
   parameter int N  = 8
) (
   input  logic          clk_i,
   input  logic          srst_i,
   input  logic          sob_i,
   input  logic          eob_i,
   input  logic [DW-1:0] freq_re_i,
   input  logic [DW-1:0] freq_im_i,
   output logic [DW-1:0] sample_o,
   output logic          sample_en_o
);

   localparam int LOG2N = $clog2(N);
   localparam int AW    = acc_width(DW, N);

   logic signed [AW-1:0] acc_q, acc_d;
   logic signed [AW-1:0] bin_ext;
   logic                 in_frame_q, in_frame_d;
   logic [DW-1:0]        sample_q, sample_d;
   logic                 sample_en_q, sample_en_d;
   logic                 fire;
   logic signed [DW-1:0] rounded;
   logic                 unused_im;

   assign bin_ext   = {{LOG2N{freq_re_i[DW-1]}}, freq_re_i};
   assign unused_im = ^freq_im_i;

   // sob always restarts the sum, which also aborts any frame still open.
   always_comb begin
      acc_d      = acc_q;
      in_frame_d = in_frame_q;
      fire       = 1'b0;
      if (sob_i) begin
         acc_d      = bin_ext;
         in_frame_d = ~eob_i;
         fire       = eob_i;
      end else if (in_frame_q) begin
         acc_d = acc_q + bin_ext;
         if (eob_i) begin
            in_frame_d = 1'b0;
            fire       = 1'b1;
         end
      end
   end

   ss_idft_round #(
      .DW    (DW),
      .LOG2N (LOG2N)
   ) u_round (
      .acc_i    (acc_d),
      .sample_o (rounded)
   );

   always_comb begin
      sample_d    = fire ? rounded : sample_q;
      sample_en_d = fire;
   end

   always_ff @(posedge clk_i or negedge srst_i) begin
      if (!srst_i) begin
         acc_q       <= '0;
         in_frame_q  <= 1'b0;
         sample_q    <= '0;
         sample_en_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         in_frame_q  <= in_frame_d;
         sample_q    <= sample_d;
         sample_en_q <= sample_en_d;
      end
   end

   assign sample_o    = sample_q;
   assign sample_en_o = sample_en_q;

endmodule

// File: tb/tb_ss_idft.sv
// Scoreboard bench for ss_idft: each closed frame queues its golden mean and
// strobe cycle; the output monitor queues what the DUT actually produced.
module tb_ss_idft;

   localparam int DW = 16;
   localparam int N  = 8;

   logic          clk_i = 1'b0;
   logic          srst_i;
   logic          sob_i;
   logic          eob_i;
   logic [DW-1:0] freq_re_i;
   logic [DW-1:0] freq_im_i;
   logic [DW-1:0] sample_o;
   logic          sample_en_o;

   typedef struct {
      int     val;
      longint cyc;
   } ev_t;

   ev_t    exp_q[$];
   ev_t    got_q[$];
   longint cyc      = 0;
   int     checks   = 0;
   int     failures = 0;
   int     v[8];

   ss_idft #(
      .DW (DW),
      .N  (N)
   ) dut (
      .clk_i       (clk_i),
      .srst_i      (srst_i),
      .sob_i       (sob_i),
      .eob_i       (eob_i),
      .freq_re_i   (freq_re_i),
      .freq_im_i   (freq_im_i),
      .sample_o    (sample_o),
      .sample_en_o (sample_en_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   always @(negedge clk_i) begin
      if (sample_en_o === 1'b1)
         got_q.push_back(ev_t'{int'($signed(sample_o)), cyc});
   end

   // Round-half-up mean by explicit floor division rather than a shift.
   function automatic int golden(input longint sum);
      longint b;
      longint q;
      b = sum + N / 2;
      q = b / N;
      if ((b % N) != 0 && b < 0) q = q - 1;
      return int'(q);
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_i);
         sob_i     = 1'b0;
         eob_i     = 1'b0;
         freq_re_i = 16'($urandom);
         freq_im_i = 16'($urandom);
      end
   endtask

   task automatic send_frame(input int len, input bit close);
      longint sum;
      sum = 0;
      for (int i = 0; i < len; i++) begin
         @(negedge clk_i);
         sob_i     = (i == 0);
         eob_i     = close && (i == len - 1);
         freq_re_i = 16'(v[i]);
         freq_im_i = 16'($urandom);
         sum       = sum + v[i];
         if (eob_i) exp_q.push_back(ev_t'{golden(sum), cyc + 1});
      end
   endtask

   task automatic test_reset();
      srst_i    = 1'b1;
      sob_i     = 1'b0;
      eob_i     = 1'b0;
      freq_re_i = '0;
      freq_im_i = '0;
      #2 srst_i = 1'b0;
      #10;
      checks++;
      if (sample_o !== 16'd0) begin
         failures++;
         $display("[TB] FAIL reset_sample: got %0d expected 0", sample_o);
      end
      checks++;
      if (sample_en_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_en: got %b expected 0", sample_en_o);
      end
      @(negedge clk_i);
      srst_i = 1'b1;
      idle(2);
   endtask

   task automatic test_levels();
      ev_t e, g;
      v = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
      send_frame(8, 1); idle(1);
      v = '{8000, 0, 0, 0, 0, 0, 0, 0};
      send_frame(8, 1); idle(1);
      v = '{5000, -5000, 5000, -5000, 5000, -5000, 5000, -5000};
      send_frame(8, 1); idle(1);
      v = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
      send_frame(8, 1); idle(1);
      v = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
      send_frame(8, 1); idle(3);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         failures++;
         $display("[TB] FAIL levels_count: strobes=%0d expected=%0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
         if (g.val !== e.val || g.cyc !== e.cyc) begin
            failures++;
            $display("[TB] FAIL levels: sample=%0d at cyc %0d, expected %0d at cyc %0d", g.val, g.cyc, e.val, e.cyc);
         end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_rounding();
      ev_t e, g;
      v = '{5, 5, 2, 0, 0, 0, 0, 0};
      send_frame(8, 1); idle(1);
      v = '{-6, 0, 0, -6, 0, 0, 0, 0};
      send_frame(8, 1); idle(1);
      v = '{3, 0, 0, 0, 0, 0, 0, 0};
      send_frame(8, 1); idle(1);
      v = '{1, 1, 1, 1, 0, 0, 0, 0};
      send_frame(8, 1); idle(1);
      v = '{100, 0, 0, 0, 0, 0, 0, 0};
      send_frame(1, 1); idle(1);
      v = '{-100, 0, 0, 0, 0, 0, 0, 0};
      send_frame(1, 1); idle(3);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         failures++;
         $display("[TB] FAIL rounding_count: strobes=%0d expected=%0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
         if (g.val !== e.val || g.cyc !== e.cyc) begin
            failures++;
            $display("[TB] FAIL rounding: sample=%0d at cyc %0d, expected %0d at cyc %0d", g.val, g.cyc, e.val, e.cyc);
         end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_back_to_back();
      ev_t e, g;
      v = '{100, 200, 300, 400, 500, 600, 700, 800};
      send_frame(8, 1);
      v = '{-1, -2, -3, -4, -5, -6, -7, -8};
      send_frame(8, 1);
      v = '{20000, 20000, -1000, 7, 9, 0, 123, 456};
      send_frame(8, 1);
      idle(3);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         failures++;
         $display("[TB] FAIL b2b_count: strobes=%0d expected=%0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
         if (g.val !== e.val || g.cyc !== e.cyc) begin
            failures++;
            $display("[TB] FAIL b2b: sample=%0d at cyc %0d, expected %0d at cyc %0d", g.val, g.cyc, e.val, e.cyc);
         end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_abort_and_stray();
      ev_t e, g;
      v = '{3000, 3000, 3000, 0, 0, 0, 0, 0};
      send_frame(3, 0);
      v = '{800, 800, 800, 800, 800, 800, 800, 800};
      send_frame(8, 1); idle(2);
      @(negedge clk_i);
      sob_i = 1'b0; eob_i = 1'b1; freq_re_i = 16'd4000;
      idle(2);
      @(negedge clk_i);
      sob_i = 1'b0; eob_i = 1'b1; freq_re_i = 16'hC000;
      idle(3);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         failures++;
         $display("[TB] FAIL abort_count: strobes=%0d expected=%0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
         if (g.val !== e.val || g.cyc !== e.cyc) begin
            failures++;
            $display("[TB] FAIL abort: sample=%0d at cyc %0d, expected %0d at cyc %0d", g.val, g.cyc, e.val, e.cyc);
         end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_reset_mid_frame();
      ev_t e, g;
      v = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
      send_frame(8, 1); idle(2);
      v = '{500, 500, 500, 0, 0, 0, 0, 0};
      send_frame(3, 0);
      @(negedge clk_i);
      srst_i = 1'b0; sob_i = 1'b0; eob_i = 1'b0;
      #1;
      checks++;
      if (sample_o !== 16'd0) begin
         failures++;
         $display("[TB] FAIL midreset_sample: got %0d expected 0", sample_o);
      end
      checks++;
      if (sample_en_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midreset_en: got %b expected 0", sample_en_o);
      end
      repeat (2) @(negedge clk_i);
      srst_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         sob_i = 1'b0; eob_i = (i == 4); freq_re_i = 16'd500;
      end
      idle(2);
      v = '{-200, -200, -200, -200, -200, -200, -200, -200};
      send_frame(8, 1); idle(3);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         failures++;
         $display("[TB] FAIL midreset_count: strobes=%0d expected=%0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
         if (g.val !== e.val || g.cyc !== e.cyc) begin
            failures++;
            $display("[TB] FAIL midreset: sample=%0d at cyc %0d, expected %0d at cyc %0d", g.val, g.cyc, e.val, e.cyc);
         end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_random();
      ev_t e, g;
      logic signed [15:0] r;
      for (int f = 0; f < 1000; f++) begin
         for (int i = 0; i < 8; i++) begin
            r    = 16'($urandom);
            v[i] = int'(r);
         end
         send_frame(8, 1);
         idle(int'($urandom_range(0, 2)));
      end
      idle(3);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         failures++;
         $display("[TB] FAIL random_count: strobes=%0d expected=%0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
         if (g.val !== e.val || g.cyc !== e.cyc) begin
            failures++;
            $display("[TB] FAIL random: sample=%0d at cyc %0d, expected %0d at cyc %0d", g.val, g.cyc, e.val, e.cyc);
         end
      end
      exp_q.delete(); got_q.delete();
   endtask

   initial begin
      test_reset();
      test_levels();
      test_rounding();
      test_back_to_back();
      test_abort_and_stray();
      test_reset_mid_frame();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
